// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution window address generator.
// Holds the FSM state type, the image-size lookup and the window size limit.
package conv_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } conv_state_e;

    localparam int MAX_KSIZE = 7;
    // Tap counters must hold 0..MAX_KSIZE-1.
    localparam int TAP_W = $clog2(MAX_KSIZE + 1);

    // Square image side selector -> log2 of the side (64, 128, 256, 512).
    function automatic logic [3:0] size_to_log2w(input logic [1:0] size_sel);
        logic [3:0] log2w;
        case (size_sel)
            2'b00:   log2w = 4'd6;
            2'b01:   log2w = 4'd7;
            2'b10:   log2w = 4'd8;
            default: log2w = 4'd9;
        endcase
        return log2w;
    endfunction

endpackage

// File: rtl/conv_tap_addr.sv
// Combinational tap address: offsets the centre by (dr,dc), applies the border rule
// and composes the byte address. Zero padding instead of clamping with CONV_WIN_ZERO_PAD_EN.
module conv_tap_addr
    import conv_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                COORD_W    = 16,
    parameter int                KSIZE      = 3,
    parameter int                ELEM_SHIFT = 0,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
    input  logic [COORD_W-1:0] row,
    input  logic [COORD_W-1:0] col,
    input  logic [TAP_W-1:0]   dr,
    input  logic [TAP_W-1:0]   dc,
    input  logic [3:0]         log2w,
    output logic [ADDR_W-1:0]  addr,
    output logic               pad
);

    // Two extra bits keep both the negative offset and the +KSIZE/2 overshoot representable.
    localparam int SW   = COORD_W + 2;
    localparam int HALF = KSIZE / 2;
    localparam logic signed [SW-1:0] ZERO = '0;
    localparam logic signed [SW-1:0] ONE  = SW'(1);

    logic signed [SW-1:0] w_val;
    logic signed [SW-1:0] r_full;
    logic signed [SW-1:0] c_full;
    logic signed [SW-1:0] r_sel;
    logic signed [SW-1:0] c_sel;
    logic [ADDR_W-1:0]    pix;

    function automatic logic signed [SW-1:0] clamp(input logic signed [SW-1:0] v,
                                                   input logic signed [SW-1:0] w);
        logic signed [SW-1:0] res;
        if (v < ZERO)
            res = ZERO;
        else if (v >= w)
            res = w - ONE;
        else
            res = v;
        return res;
    endfunction

    always_comb begin
        w_val  = $signed(SW'(1) << log2w);
        r_full = $signed({2'b00, row}) + $signed(SW'(dr)) - $signed(SW'(HALF));
        c_full = $signed({2'b00, col}) + $signed(SW'(dc)) - $signed(SW'(HALF));
`ifdef CONV_WIN_ZERO_PAD_EN
        r_sel = r_full;
        c_sel = c_full;
        pad   = (r_full < ZERO) || (r_full >= w_val) || (c_full < ZERO) || (c_full >= w_val);
`else
        r_sel = clamp(r_full, w_val);
        c_sel = clamp(c_full, w_val);
        pad   = 1'b0;
`endif
        pix  = (ADDR_W'(r_sel) << log2w) + ADDR_W'(c_sel);
        addr = BASE_ADDR + (pix << ELEM_SHIFT);
`ifdef CONV_WIN_ZERO_PAD_EN
        if (pad)
            addr = BASE_ADDR;
`endif
    end

endmodule

// File: rtl/conv_window_addr_gen.sv
// Streams the KSIZE x KSIZE neighbourhood of one centre pixel as byte addresses, one tap
// per accepted handshake. Optional zero padding at the border via CONV_WIN_ZERO_PAD_EN.
module conv_window_addr_gen
    import conv_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                COORD_W    = 16,
    parameter int                KSIZE      = 3,
    parameter int                ELEM_SHIFT = 0,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h0
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [1:0]           SIZE_IMAGE_SRC,
    input  logic [2*COORD_W-1:0] INDEX_ADDRESS,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    output logic [ADDR_W-1:0]    MEM_ADDRESS,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic                 OUT_LAST,
    output logic                 OUT_PAD
);

    localparam logic [TAP_W-1:0] K_LAST = TAP_W'(KSIZE - 1);

    conv_state_e        state_reg;
    logic [COORD_W-1:0] row_reg;
    logic [COORD_W-1:0] col_reg;
    logic [3:0]         log2w_reg;
    logic [TAP_W-1:0]   dr_reg;
    logic [TAP_W-1:0]   dc_reg;
    logic               in_ready_reg;
    logic               out_valid_reg;
    logic               out_last_reg;
    logic               out_pad_reg;
    logic [ADDR_W-1:0]  mem_address_reg;

    logic [TAP_W-1:0]   dr_next;
    logic [TAP_W-1:0]   dc_next;
    logic [COORD_W-1:0] tap_row;
    logic [COORD_W-1:0] tap_col;
    logic [TAP_W-1:0]   tap_dr;
    logic [TAP_W-1:0]   tap_dc;
    logic [3:0]         tap_log2w;
    logic               tap_last;
    logic [ADDR_W-1:0]  tap_addr;
    logic               tap_pad;

    // The address unit always sees the tap that will be registered next: tap 0 of the
    // incoming request while idle, otherwise the successor of the tap on the outputs.
    always_comb begin
        dc_next = (dc_reg == K_LAST) ? '0 : dc_reg + 1'b1;
        dr_next = (dc_reg == K_LAST) ? dr_reg + 1'b1 : dr_reg;
        if (state_reg == IDLE) begin
            tap_row   = INDEX_ADDRESS[2*COORD_W-1 -: COORD_W];
            tap_col   = INDEX_ADDRESS[COORD_W-1:0];
            tap_dr    = '0;
            tap_dc    = '0;
            tap_log2w = size_to_log2w(SIZE_IMAGE_SRC);
        end else begin
            tap_row   = row_reg;
            tap_col   = col_reg;
            tap_dr    = dr_next;
            tap_dc    = dc_next;
            tap_log2w = log2w_reg;
        end
        tap_last = (tap_dr == K_LAST) && (tap_dc == K_LAST);
    end

    conv_tap_addr #(
        .ADDR_W    (ADDR_W),
        .COORD_W   (COORD_W),
        .KSIZE     (KSIZE),
        .ELEM_SHIFT(ELEM_SHIFT),
        .BASE_ADDR (BASE_ADDR)
    ) u_tap_addr (
        .row  (tap_row),
        .col  (tap_col),
        .dr   (tap_dr),
        .dc   (tap_dc),
        .log2w(tap_log2w),
        .addr (tap_addr),
        .pad  (tap_pad)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_reg       <= IDLE;
            row_reg         <= '0;
            col_reg         <= '0;
            log2w_reg       <= '0;
            dr_reg          <= '0;
            dc_reg          <= '0;
            in_ready_reg    <= 1'b1;
            out_valid_reg   <= 1'b0;
            out_last_reg    <= 1'b0;
            out_pad_reg     <= 1'b0;
            mem_address_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (IN_VALID) begin
                        state_reg       <= EMIT;
                        in_ready_reg    <= 1'b0;
                        row_reg         <= tap_row;
                        col_reg         <= tap_col;
                        log2w_reg       <= tap_log2w;
                        dr_reg          <= '0;
                        dc_reg          <= '0;
                        out_valid_reg   <= 1'b1;
                        out_last_reg    <= tap_last;
                        out_pad_reg     <= tap_pad;
                        mem_address_reg <= tap_addr;
                    end
                end
                EMIT: begin
                    // OUT_VALID is always high here, so OUT_READY alone completes a handshake.
                    if (OUT_READY) begin
                        if (out_last_reg) begin
                            state_reg     <= IDLE;
                            in_ready_reg  <= 1'b1;
                            out_valid_reg <= 1'b0;
                            out_last_reg  <= 1'b0;
                            out_pad_reg   <= 1'b0;
                        end else begin
                            dr_reg          <= dr_next;
                            dc_reg          <= dc_next;
                            out_last_reg    <= tap_last;
                            out_pad_reg     <= tap_pad;
                            mem_address_reg <= tap_addr;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign IN_READY    = in_ready_reg;
    assign OUT_VALID   = out_valid_reg;
    assign OUT_LAST    = out_last_reg;
    assign OUT_PAD     = out_pad_reg;
    assign MEM_ADDRESS = mem_address_reg;

endmodule

// File: tb/tb_conv_window_addr_gen.sv
// Bench for conv_window_addr_gen: two instances (ELEM_SHIFT 0 and 2) share the stimulus and
// are checked every cycle against a window model, plus literal expectations per scenario.
module tb_conv_window_addr_gen;

    localparam int K    = 3;
    localparam int HALF = K / 2;

    typedef struct packed {
        logic [31:0] addr;
        logic        last;
        logic        pad;
    } tap_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  size_src;
    logic [31:0] index;
    logic        in_valid;
    logic        out_ready;

    logic        in_ready0, valid0, last0, pad0;
    logic [31:0] addr0;
    logic        in_ready1, valid1, last1, pad1;
    logic [31:0] addr1;

    tap_t        q0[$];
    tap_t        q1[$];
    tap_t        log0[$];
    logic [31:0] last_addr1;
    int          vectors     = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    conv_window_addr_gen #(
        .ADDR_W(32), .COORD_W(16), .KSIZE(K), .ELEM_SHIFT(0), .BASE_ADDR(32'h0)
    ) u_dut0 (
        .CLK(clk), .RESET(rst_n), .SIZE_IMAGE_SRC(size_src), .INDEX_ADDRESS(index),
        .IN_VALID(in_valid), .IN_READY(in_ready0), .MEM_ADDRESS(addr0), .OUT_VALID(valid0),
        .OUT_READY(out_ready), .OUT_LAST(last0), .OUT_PAD(pad0)
    );

    conv_window_addr_gen #(
        .ADDR_W(32), .COORD_W(16), .KSIZE(K), .ELEM_SHIFT(2), .BASE_ADDR(32'h0)
    ) u_dut1 (
        .CLK(clk), .RESET(rst_n), .SIZE_IMAGE_SRC(size_src), .INDEX_ADDRESS(index),
        .IN_VALID(in_valid), .IN_READY(in_ready1), .MEM_ADDRESS(addr1), .OUT_VALID(valid1),
        .OUT_READY(out_ready), .OUT_LAST(last1), .OUT_PAD(pad1)
    );

    // Expected tap from the plain geometric rule: offset, border handling, r*W+c scaled.
    function automatic tap_t model_tap(input int row, input int col, input int sz,
                                       input int shift, input int dr, input int dc);
        tap_t t;
        int   w;
        int   r;
        int   c;
        w = 64 << sz;
        r = row + dr - HALF;
        c = col + dc - HALF;
        t.last = (dr == K - 1) && (dc == K - 1);
        t.pad  = 1'b0;
`ifdef CONV_WIN_ZERO_PAD_EN
        if (r < 0 || r >= w || c < 0 || c >= w) begin
            t.pad  = 1'b1;
            t.addr = 32'd0;
        end else begin
            t.addr = 32'((r * w + c) << shift);
        end
`else
        if (r < 0) r = 0;
        if (r > w - 1) r = w - 1;
        if (c < 0) c = 0;
        if (c > w - 1) c = w - 1;
        t.addr = 32'((r * w + c) << shift);
`endif
        return t;
    endfunction

    task automatic push_window(input int row, input int col, input int sz);
        for (int dr = 0; dr < K; dr++)
            for (int dc = 0; dc < K; dc++) begin
                q0.push_back(model_tap(row, col, sz, 0, dr, dc));
                q1.push_back(model_tap(row, col, sz, 2, dr, dc));
            end
    endtask

    task automatic check_dut(input int id, input logic v, input logic [31:0] a,
                             input logic l, input logic p);
        tap_t exp_t;
        if (!v) return;
        vectors++;
        if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
            miscompares++;
            $display("FAIL unexpected_tap dut%0d: got addr=%0d, required no valid tap", id, a);
            return;
        end
        exp_t = (id == 0) ? q0[0] : q1[0];
        if (a !== exp_t.addr || l !== exp_t.last || p !== exp_t.pad) begin
            miscompares++;
            $display("FAIL tap dut%0d: got addr=%0d last=%b pad=%b, required addr=%0d last=%b pad=%b",
                     id, a, l, p, exp_t.addr, exp_t.last, exp_t.pad);
        end
        if (out_ready) begin
            $display("tap dut%0d addr=%0d last=%b pad=%b", id, a, l, p);
            if (id == 0) begin
                void'(q0.pop_front());
                log0.push_back('{addr: a, last: l, pad: p});
            end else begin
                void'(q1.pop_front());
                if (l) last_addr1 = a;
            end
        end
    endtask

    // Per-cycle compare of both instances against the model queues.
    always @(negedge clk) begin
        if (!rst_n) begin
            vectors++;
            if (valid0 !== 1'b0 || valid1 !== 1'b0) begin
                miscompares++;
                $display("FAIL valid_in_reset: got %b/%b, required 0/0", valid0, valid1);
            end
        end else begin
            check_dut(0, valid0, addr0, last0, pad0);
            check_dut(1, valid1, addr1, last1, pad1);
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        vectors++;
        if (got !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    task automatic accept_req(input int row, input int col, input int sz);
        int budget;
        budget = 0;
        while (in_ready0 !== 1'b1 && budget < 50) begin
            @(posedge clk); #1;
            budget++;
        end
        check("accept_ready", 32'(in_ready0), 32'd1);
        log0.delete();
        index    = {16'(row), 16'(col)};
        size_src = 2'(sz);
        in_valid = 1'b1;
        @(posedge clk);
        push_window(row, col, sz);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(output int cycles);
        cycles = 0;
        while ((q0.size() != 0 || q1.size() != 0) && cycles < 200) begin
            @(posedge clk); #1;
            cycles++;
        end
        check("drain_left", 32'(q0.size() + q1.size()), 32'd0);
    endtask

    task automatic check_window(input string name, input int exp_a[9], input logic [8:0] exp_pad);
        vectors++;
        if (log0.size() != 9) begin
            miscompares++;
            $display("FAIL %s_count: got %0d taps, required 9", name, log0.size());
        end else begin
            for (int i = 0; i < 9; i++) begin
                vectors++;
                if (log0[i].addr !== 32'(exp_a[i]) || log0[i].pad !== exp_pad[i] ||
                    log0[i].last !== (i == 8)) begin
                    miscompares++;
                    $display("FAIL %s_tap%0d: got addr=%0d pad=%b last=%b, required addr=%0d pad=%b last=%b",
                             name, i, log0[i].addr, log0[i].pad, log0[i].last,
                             exp_a[i], exp_pad[i], (i == 8));
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        int exp_a[9];
        logic [8:0] exp_p;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; size_src = 2'b10; index = '0;
        last_addr1 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", 32'(in_ready0), 32'd1);
        check("reset_valid", 32'(valid0), 32'd0);
        check("reset_addr", addr0, 32'd0);
        check("reset_last", 32'(last0), 32'd0);
        check("reset_pad", 32'(pad0), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: interior centre, full throughput
        accept_req(1, 2, 2);
        drain(cyc);
        check("t1_cycles", 32'(cyc), 32'd9);
        check("t1_idle_ready", 32'(in_ready0), 32'd1);
        check("t1_idle_valid", 32'(valid0), 32'd0);
        exp_a = '{1, 2, 3, 257, 258, 259, 513, 514, 515};
        check_window("t1", exp_a, 9'b0);

        // 2/3: top-left corner
        accept_req(0, 0, 2);
        drain(cyc);
`ifdef CONV_WIN_ZERO_PAD_EN
        exp_a = '{0, 0, 0, 0, 0, 1, 0, 256, 257};
        exp_p = 9'b001001111;
`else
        exp_a = '{0, 0, 1, 0, 0, 1, 256, 256, 257};
        exp_p = 9'b000000000;
`endif
        check_window("t23", exp_a, exp_p);

        // 4: stall three cycles on tap 4
        accept_req(1, 2, 2);
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_stall_addr", addr0, 32'd258);
            check("t4_stall_valid", 32'(valid0), 32'd1);
            @(posedge clk);
        end
        #1;
        out_ready = 1'b1;
        drain(cyc);
        exp_a = '{1, 2, 3, 257, 258, 259, 513, 514, 515};
        check_window("t4", exp_a, 9'b0);

        // 5: bottom-right corner of 512x512, size selector toggled mid-window
        accept_req(511, 511, 3);
        size_src = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        size_src = 2'b01;
        drain(cyc);
        size_src = 2'b10;
`ifdef CONV_WIN_ZERO_PAD_EN
        check("t5_last_addr_e2", last_addr1, 32'd0);
        exp_a = '{261630, 261631, 0, 262142, 262143, 0, 0, 0, 0};
        exp_p = 9'b111100100;
`else
        check("t5_last_addr_e2", last_addr1, 32'd1048572);
        exp_a = '{261630, 261631, 261631, 262142, 262143, 262143, 262142, 262143, 262143};
        exp_p = 9'b000000000;
`endif
        check_window("t5", exp_a, exp_p);

        // 6: asynchronous reset mid-window, then a fresh request
        accept_req(1, 2, 2);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        #1;
        check("t6_reset_valid", 32'(valid0), 32'd0);
        check("t6_reset_ready", 32'(in_ready0), 32'd1);
        check("t6_reset_valid_e2", 32'(valid1), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        accept_req(1, 2, 2);
        drain(cyc);
        check("t6_cycles", 32'(cyc), 32'd9);
        exp_a = '{1, 2, 3, 257, 258, 259, 513, 514, 515};
        check_window("t6", exp_a, 9'b0);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
